// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: default widths, latency helper and
// the per-stage record carried down the Montgomery multiplier pipeline.
package ntt_pkg;

    localparam int DW_DEF   = 32;
    localparam int WW_DEF   = 8;
    localparam int TAGW_DEF = 8;

    function automatic int wlm_lat(input int dw, input int ww);
        return dw / ww + 2;
    endfunction

    typedef struct packed {
        logic                         valid;
        logic [2*DW_DEF-1:0]          t;
        logic [DW_DEF-WW_DEF-1:0]     qh;
        logic [TAGW_DEF-1:0]          tag;
    } wlm_stage_t;

endpackage

// File: rtl/wlm_reduce_step.sv
// One word-level Montgomery reduction step for q = qH*2^WW + 1:
// T' = (T + m*q) >> WW, computed without forming m*q or the cancelled low word.
module wlm_reduce_step
    import ntt_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic [2*DW-1:0]  t_i,
    input  logic [DW-WW-1:0] qh_i,
    output logic [2*DW-1:0]  t_o
);

    logic [WW-1:0] lo;
    logic [WW-1:0] m;
    logic          cy;
    logic [DW-1:0] mq;

    assign lo = t_i[WW-1:0];
    assign m  = -lo;
    // lo + m is either 0 or exactly 2^WW, so the carry is just "lo nonzero"
    assign cy = |lo;
    assign mq = {{(DW-WW){1'b0}}, m} * {{WW{1'b0}}, qh_i};

    assign t_o = (t_i >> WW)
               + {{DW{1'b0}}, mq}
               + {{(2*DW-1){1'b0}}, cy};

endmodule

// File: rtl/wlm_mod_mul.sv
// Pipelined word-level Montgomery multiplier: c = a*b*2^-DW mod q,
// one op per cycle, global stall on en, tag carried alongside.
module wlm_mod_mul
    import ntt_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int WW   = WW_DEF,
    parameter int TAGW = TAGW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   q,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    output logic [DW-1:0]   c,
    output logic [TAGW-1:0] out_tag
);

    localparam int LAT = wlm_lat(DW, WW);
    localparam int NS  = LAT - 2;
    localparam int TW  = 2 * DW;
    localparam int QHW = DW - WW;

    if (DW % WW != 0) begin : g_bad_ww
        $error("wlm_mod_mul: DW must be a multiple of WW");
    end

    typedef struct packed {
        logic            valid;
        logic [TW-1:0]   t;
        logic [QHW-1:0]  qh;
        logic [TAGW-1:0] tag;
    } stage_t;

    // [0] operands {a,b}, [1] product P, [2..NS+1] after R1..R(NS)
    stage_t st_q [0:NS+1];
    stage_t st_d [0:NS+1];

    logic [TW-1:0] t_red [1:NS];
    logic [TW-1:0] op_a;
    logic [TW-1:0] op_b;
    logic [TW-1:0] prod;

    logic            vld_q;
    logic [DW-1:0]   c_q;
    logic [DW-1:0]   c_d;
    logic [TAGW-1:0] tag_q;

    stage_t        fin;
    logic [DW-1:0] q_full;
    logic          ge;
    logic          unused_q_lo;

    assign unused_q_lo = ^q[WW-1:0];

    assign st_d[0] = {in_valid, a, b, q[DW-1:WW], in_tag};

    assign op_a = {{DW{1'b0}}, st_q[0].t[TW-1:DW]};
    assign op_b = {{DW{1'b0}}, st_q[0].t[DW-1:0]};
    assign prod = op_a * op_b;

    assign st_d[1] = {st_q[0].valid, prod, st_q[0].qh, st_q[0].tag};

    for (genvar k = 1; k <= NS; k++) begin : g_red
        wlm_reduce_step #(
            .DW (DW),
            .WW (WW)
        ) u_step (
            .t_i  (st_q[k].t),
            .qh_i (st_q[k].qh),
            .t_o  (t_red[k])
        );

        assign st_d[k+1] = {st_q[k].valid, t_red[k], st_q[k].qh, st_q[k].tag};
    end

    // T < 2q on entry here, so one conditional subtract lands in [0, q)
    assign fin    = st_q[NS+1];
    assign q_full = {fin.qh, WW'(1)};
    assign ge     = fin.t >= {{DW{1'b0}}, q_full};
    assign c_d    = ge ? (fin.t[DW-1:0] - q_full) : fin.t[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NS + 1; i++) begin
                st_q[i] <= '0;
            end
            vld_q <= 1'b0;
            c_q   <= '0;
            tag_q <= '0;
        end else if (en) begin
            for (int i = 0; i <= NS + 1; i++) begin
                st_q[i] <= st_d[i];
            end
            vld_q <= fin.valid;
            if (fin.valid) begin
                c_q   <= c_d;
                tag_q <= fin.tag;
            end
        end
    end

    assign out_valid = vld_q;
    assign c         = c_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_wlm_mod_mul.sv
// Scoreboard bench for wlm_mod_mul: expected results come from a bit-serial
// Montgomery reference (halving mod q 32 times) and are queued at drive time.
module tb_wlm_mod_mul;

    localparam int LAT = 6;

    typedef struct {
        logic [31:0] c;
        logic [7:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic [31:0] c;
    logic [7:0]  out_tag;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    wlm_mod_mul u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .q         (q),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .c         (c),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mont(input longint unsigned av,
                                         input longint unsigned bv,
                                         input longint unsigned qv);
        longint unsigned x;
        x = (av * bv) % qv;
        for (int i = 0; i < 32; i++) begin
            if (x[0]) x = (x + qv) >> 1;
            else      x = x >> 1;
        end
        return x[31:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] qv,
                         input logic [7:0] tg, input bit sb);
        exp_t e;
        in_valid = v;
        a        = av;
        b        = bv;
        q        = qv;
        in_tag   = tg;
        if (sb && v && en) begin
            e.c   = mont(av, bv, qv);
            e.tag = tg;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        drive(1'b0, 0, 0, 12289, 0, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b required 0", out_valid);
        end
        n_cmp++;
        if (c !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_c: got %0d required 0", c);
        end
        n_cmp++;
        if (out_tag !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_tag: got %0d required 0", out_tag);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero;
        @(negedge clk);
        drive(1'b1, 0, 12288, 12289, 8'h5A, 1'b0);
        for (int i = 1; i <= LAT + 4; i++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 12289, 0, 1'b0);
            n_cmp++;
            if (out_valid !== (i == LAT + 1)) begin
                n_bad++;
                $display("FAIL zero_lat: edge %0d out_valid=%b required %b",
                         i, out_valid, (i == LAT + 1));
            end
            if (i == LAT + 1) begin
                n_cmp++;
                if (c !== 32'd0 || out_tag !== 8'h5A) begin
                    n_bad++;
                    $display("FAIL zero_val: c=%0d tag=%0h required c=0 tag=5a",
                             c, out_tag);
                end
            end
        end
    endtask

    task automatic test_known;
        logic [31:0] r_mod;
        longint unsigned r64;
        exp_t e;
        int nseen;
        r64   = (64'd1 << 32) % 64'd12289;
        r_mod = r64[31:0];
        nseen = 0;
        @(negedge clk);
        drive(1'b1, r_mod, 5, 12289, 8'd1, 1'b1);
        @(negedge clk);
        drive(1'b1, 12288, 12288, 12289, 8'd2, 1'b1);
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 12289, 0, 1'b0);
            if (out_valid === 1'b1) begin
                nseen++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL known_extra: c=%0d with empty scoreboard", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e.c || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL known_data: c=%0d tag=%0d required c=%0d tag=%0d",
                                 c, out_tag, e.c, e.tag);
                    end
                end
                n_cmp++;
                if (nseen == 1 && c !== 32'd5) begin
                    n_bad++;
                    $display("FAIL known_r5: c=%0d required 5", c);
                end else if (nseen == 2 && c >= 32'd12289) begin
                    n_bad++;
                    $display("FAIL known_range: c=%0d required < 12289", c);
                end
            end
        end
        n_cmp++;
        if (nseen != 2) begin
            n_bad++;
            $display("FAIL known_count: got %0d outputs required 2", nseen);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] qs [3];
        logic [31:0] qv;
        exp_t e;
        int nout;
        int first;
        int last;
        qs[0] = 32'd12289;
        qs[1] = 32'd7681;
        qs[2] = 32'd8380417;
        nout  = 0;
        first = -1;
        last  = -1;
        exp_q.delete();
        for (int it = 0; it < 1000 + LAT + 4; it++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                nout++;
                if (first < 0) first = it;
                last = it;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: c=%0d with empty scoreboard", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e.c || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL b2b_data: c=%0d tag=%0d required c=%0d tag=%0d",
                                 c, out_tag, e.c, e.tag);
                    end
                end
            end
            if (it < 1000) begin
                qv = qs[it % 3];
                drive(1'b1, $urandom_range(qv - 1), $urandom_range(qv - 1),
                      qv, it[7:0], 1'b1);
            end else begin
                drive(1'b0, 0, 0, 12289, 0, 1'b0);
            end
        end
        n_cmp++;
        if (nout != 1000 || last - first != 999) begin
            n_bad++;
            $display("FAIL b2b_rate: %0d outs over %0d cycles required 1000 over 1000",
                     nout, last - first + 1);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_left: %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        exp_t e;
        int k;
        int nout;
        int last;
        logic        sv;
        logic [31:0] sc;
        logic [7:0]  st;
        k    = 0;
        nout = 0;
        last = -1;
        sv   = 1'b0;
        sc   = '0;
        st   = '0;
        exp_q.delete();
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            if (it >= 5 && it <= 7) begin
                n_cmp++;
                if (out_valid !== sv || c !== sc || out_tag !== st) begin
                    n_bad++;
                    $display("FAIL stall_freeze: v=%b c=%0d tag=%0d required v=%b c=%0d tag=%0d",
                             out_valid, c, out_tag, sv, sc, st);
                end
            end
            if (out_valid === 1'b1 && !(it >= 5 && it <= 7)) begin
                nout++;
                last = it;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra: c=%0d with empty scoreboard", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e.c || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL stall_data: c=%0d tag=%0d required c=%0d tag=%0d",
                                 c, out_tag, e.c, e.tag);
                    end
                end
            end
            if (it == 4) begin
                sv = out_valid;
                sc = c;
                st = out_tag;
            end
            en = !(it >= 4 && it <= 6);
            if (en && k < 10) begin
                drive(1'b1, $urandom_range(12288), $urandom_range(12288),
                      12289, 8'(8'h80 + k), 1'b1);
                k++;
            end else begin
                drive(en ? 1'b0 : 1'b1, 1, 1, 12289, 8'hFF, 1'b1);
            end
        end
        en = 1'b1;
        n_cmp++;
        if (nout != 10 || last != 9 + LAT + 1 + 3) begin
            n_bad++;
            $display("FAIL stall_count: %0d outs last at %0d required 10 last at %0d",
                     nout, last, 9 + LAT + 1 + 3);
        end
    endtask

    task automatic test_bubble;
        logic pat [4];
        exp_t e;
        logic want;
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;
        exp_q.delete();
        for (int it = 0; it < 4 + LAT + 4; it++) begin
            @(negedge clk);
            want = (it >= LAT + 1 && it <= LAT + 4) ? pat[it - LAT - 1] : 1'b0;
            n_cmp++;
            if (out_valid !== want) begin
                n_bad++;
                $display("FAIL bubble_valid: step %0d got %b required %b",
                         it, out_valid, want);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bubble_extra: c=%0d with empty scoreboard", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e.c || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL bubble_data: c=%0d tag=%0d required c=%0d tag=%0d",
                                 c, out_tag, e.c, e.tag);
                    end
                end
            end
            if (it < 4) drive(pat[it], 1234 + it, 5678, 12289, 8'(8'h40 + it), 1'b1);
            else        drive(1'b0, 0, 0, 12289, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int nout;
        nout = 0;
        exp_q.delete();
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            drive(1'b1, 100 + it, 200, 7681, 8'(8'h20 + it), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 0, 0, 7681, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || c !== 32'd0 || out_tag !== 8'd0) begin
            n_bad++;
            $display("FAIL rstmid_async: v=%b c=%0d tag=%0d required 0 0 0",
                     out_valid, c, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int it = 0; it < LAT + 6; it++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_stale: step %0d out_valid=%b required 0",
                         it, out_valid);
            end
        end
        drive(1'b1, 4321, 8765, 8380417, 8'h77, 1'b1);
        for (int it = 0; it < LAT + 4; it++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 8380417, 0, 1'b0);
            if (out_valid === 1'b1) begin
                nout++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rstmid_extra: c=%0d with empty scoreboard", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e.c || out_tag !== e.tag) begin
                        n_bad++;
                        $display("FAIL rstmid_data: c=%0d tag=%0d required c=%0d tag=%0d",
                                 c, out_tag, e.c, e.tag);
                    end
                end
            end
        end
        n_cmp++;
        if (nout != 1) begin
            n_bad++;
            $display("FAIL rstmid_count: %0d outs required 1", nout);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_zero();
        test_known();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
